systolic_ctrl_8x8: RTL and testbench

Sequencing controller for the 8x8 output-stationary systolic array. On `start` it clears the array accumulators and streams `k_len` A-columns and B-rows from tile memory. It applies the per-row and per-column input skew the array requires, flushes the pipeline with zeros, and pulses `done` when every C element is final. It runs on the array's buffered clock domain, between the tile buffers and the array.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/skew_line_8.sv | 33 +++
 rtl/systolic_ctrl_8x8.sv | 137 +++++++++++++
 tb/tb_systolic_ctrl_8x8.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the 8x8 output-stationary systolic array controller.
package systolic_pkg;

  localparam int unsigned ARR_N        = 8;
  localparam int unsigned DRAIN_CYCLES = 2 * (ARR_N - 1) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/skew_line_8.sv
// Triangular delay line: lane n of the flat bus is delayed n cycles; clr_i zeroes every stage.
module skew_line_8
  import systolic_pkg::*;
#(
  parameter int unsigned LANES = ARR_N,
  parameter int unsigned W     = 8
) (
  input  logic               clk,
  input  logic               clr_i,
  input  logic [LANES*W-1:0] din_i,
  output logic [LANES*W-1:0] dout_o
);

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    if (n == 0) begin : g_pass
      assign dout_o[W-1:0] = din_i[W-1:0];
    end else begin : g_dly
      logic [W-1:0] sr_q [n];

      always_ff @(posedge clk) begin
        if (clr_i) begin
          for (int s = 0; s < n; s++) sr_q[s] <= '0;
        end else begin
          sr_q[0] <= din_i[n*W +: W];
          for (int s = 1; s < n; s++) sr_q[s] <= sr_q[s-1];
        end
      end

      assign dout_o[n*W +: W] = sr_q[n-1];
    end
  end

endmodule

// File: rtl/systolic_ctrl_8x8.sv
// Run sequencer for the 8x8 systolic array: clear, feed K skewed beats, drain, signal done.
module systolic_ctrl_8x8
  import systolic_pkg::*;
#(
  parameter int unsigned data_width = 8,
  parameter int unsigned k_width    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [k_width-1:0]          k_len,
  input  logic                        arr_locked,
  output logic                        mem_rd_en,
  output logic [k_width-1:0]          mem_addr,
  input  logic [ARR_N*data_width-1:0] mem_a_data,
  input  logic [ARR_N*data_width-1:0] mem_b_data,
  output logic [ARR_N*data_width-1:0] a_in_flat,
  output logic [ARR_N*data_width-1:0] b_in_flat,
  output logic                        arr_en,
  output logic                        arr_clr,
  output logic                        busy,
  output logic                        done,
  output logic                        abort
);

  localparam int unsigned CNT_W = k_width + 1;
  localparam int unsigned BUS_W = ARR_N * data_width;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [k_width-1:0] k_q, k_d;
  logic [k_width-1:0] addr_d;
  logic               rd_vld_q;
  logic               rd_en_d, arr_en_d, arr_clr_d, busy_d, done_d;
  logic               abort_c, skew_clr_c;
  logic [BUS_W-1:0]   a_gate_c, b_gate_c;

  // Next state, shared FEED/DRAIN counter and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    abort_c = (state_q inside {ST_CLEAR, ST_FEED, ST_DRAIN}) && !arr_locked;

    case (state_q)
      ST_IDLE: begin
        if (start && arr_locked) begin
          state_d = ST_CLEAR;
          k_d     = k_len;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = (k_q == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        if (cnt_q == CNT_W'(k_q) - CNT_W'(1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    rd_en_d   = (state_d == ST_FEED);
    addr_d    = rd_en_d ? k_width'(cnt_d) : '0;
    arr_en_d  = (state_d == ST_FEED) || (state_d == ST_DRAIN);
    arr_clr_d = (state_d == ST_CLEAR);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      rd_vld_q  <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      arr_en    <= 1'b0;
      arr_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      rd_vld_q  <= mem_rd_en && !abort_c;
      mem_rd_en <= rd_en_d;
      mem_addr  <= addr_d;
      arr_en    <= arr_en_d;
      arr_clr   <= arr_clr_d;
      busy      <= busy_d;
      done      <= done_d;
      abort     <= abort_c;
    end
  end

  // Only beats returned for an issued read reach the array; lane 0 is the memory read flop itself
  assign a_gate_c   = rd_vld_q ? mem_a_data : '0;
  assign b_gate_c   = rd_vld_q ? mem_b_data : '0;
  assign skew_clr_c = rst || abort_c || (state_q == ST_CLEAR);

  skew_line_8 #(.LANES(ARR_N), .W(data_width)) u_skew_a (
    .clk    (clk),
    .clr_i  (skew_clr_c),
    .din_i  (a_gate_c),
    .dout_o (a_in_flat)
  );

  skew_line_8 #(.LANES(ARR_N), .W(data_width)) u_skew_b (
    .clk    (clk),
    .clr_i  (skew_clr_c),
    .din_i  (b_gate_c),
    .dout_o (b_in_flat)
  );

endmodule

// File: tb/tb_systolic_ctrl_8x8.sv
// Directed bench for systolic_ctrl_8x8 with a tile-memory model and a behavioural 8x8 MAC array.
module tb_systolic_ctrl_8x8;

  logic        clk = 1'b0;
  logic        rst, start, arr_locked;
  logic [7:0]  k_len;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [63:0] mem_a_data, mem_b_data, a_in_flat, b_in_flat;
  logic        arr_en, arr_clr, busy, done, abort;

  systolic_ctrl_8x8 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .arr_locked (arr_locked),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_a_data (mem_a_data),
    .mem_b_data (mem_b_data),
    .a_in_flat  (a_in_flat),
    .b_in_flat  (b_in_flat),
    .arr_en     (arr_en),
    .arr_clr    (arr_clr),
    .busy       (busy),
    .done       (done),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  // Tile memory: one-cycle read latency, garbage on the bus when not reading
  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a_data <= mem_a[mem_addr];
      mem_b_data <= mem_b[mem_addr];
    end else begin
      mem_a_data <= {$urandom, $urandom};
      mem_b_data <= {$urandom, $urandom};
    end
  end

  // Output-stationary array: A flows right, B flows down, one hop per enabled cycle
  int               acc [8][8];
  logic signed [7:0] ap [8][8];
  logic signed [7:0] bp [8][8];
  always @(posedge clk) begin
    logic signed [7:0] av, bv;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (arr_clr) begin
          acc[i][j] <= 0;
          ap[i][j]  <= '0;
          bp[i][j]  <= '0;
        end else if (arr_en) begin
          if (j == 0) av = $signed(a_in_flat[i*8 +: 8]);
          else        av = ap[i][j-1];
          if (i == 0) bv = $signed(b_in_flat[j*8 +: 8]);
          else        bv = bp[i-1][j];
          acc[i][j] <= acc[i][j] + int'(av) * int'(bv);
          ap[i][j]  <= av;
          bp[i][j]  <= bv;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc, done_cyc, n_done, n_rd, n_busy, n_abort, addr_bad, a7_cyc, exp_addr;
  logic done_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden C = A(:,0..k-1) x B(0..k-1,:) from the memory contents; returns mismatch count
  function automatic int c_errs(input int k);
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        int s = 0;
        for (int kk = 0; kk < k; kk++) begin
          logic [63:0] wa, wb;
          wa = mem_a[kk];
          wb = mem_b[kk];
          s += int'($signed(wa[i*8 +: 8])) * int'($signed(wb[j*8 +: 8]));
        end
        if (acc[i][j] != s) bad++;
      end
    end
    return bad;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    if (done === 1'b1) begin
      n_done++;
      if (done_cyc < 0) begin
        done_cyc = cyc;
        done_en  = arr_en;
      end
    end
    if (mem_rd_en === 1'b1) begin
      if (mem_addr !== 8'(exp_addr)) addr_bad++;
      exp_addr++;
      n_rd++;
    end
    if (busy === 1'b1) n_busy++;
    if (abort === 1'b1) n_abort++;
    if (a7_cyc < 0 && a_in_flat[63:56] != 8'h00) a7_cyc = cyc;
  endtask

  task automatic go(input int k);
    start    = 1'b1;
    k_len    = 8'(k);
    cyc      = 0;
    done_cyc = -1;
    done_en  = 1'bx;
    n_done   = 0;
    n_rd     = 0;
    n_busy   = 0;
    n_abort  = 0;
    addr_bad = 0;
    a7_cyc   = -1;
    exp_addr = 0;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int lim);
    while (done_cyc < 0 && cyc < lim) step();
    step();
  endtask

  initial begin
    int bad;
    rst        = 1'b1;
    start      = 1'b0;
    arr_locked = 1'b1;
    k_len      = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 0);
    chk("rst_mem_addr",  64'(mem_addr), 0);
    chk("rst_a_in",      a_in_flat, 0);
    chk("rst_b_in",      b_in_flat, 0);
    chk("rst_arr_en",    64'(arr_en), 0);
    chk("rst_arr_clr",   64'(arr_clr), 0);
    chk("rst_busy",      64'(busy), 0);
    chk("rst_done",      64'(done), 0);
    chk("rst_abort",     64'(abort), 0);
    rst = 1'b0;
    @(negedge clk);

    // K=1, A all 1, B all 2 -> C all 2
    mem_a[0] = {8{8'h01}};
    mem_b[0] = {8{8'h02}};
    go(1);
    chk("k1_clear_arr_clr", 64'(arr_clr), 1);
    chk("k1_clear_arr_en",  64'(arr_en), 0);
    chk("k1_clear_busy",    64'(busy), 1);
    step();
    chk("k1_feed_rd_en",    64'(mem_rd_en), 1);
    chk("k1_feed_arr_en",   64'(arr_en), 1);
    chk("k1_feed_arr_clr",  64'(arr_clr), 0);
    run_to_done(60);
    chk("k1_done_cycle", 64'(done_cyc), 18);
    chk("k1_done_count", 64'(n_done), 1);
    chk("k1_busy_cycles", 64'(n_busy), 18);
    chk("k1_rd_count", 64'(n_rd), 1);
    chk("k1_arr_en_at_done", 64'(done_en), 0);
    bad = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (acc[i][j] != 2) bad++;
    chk("k1_c_all_2", 64'(bad), 0);

    // K=8 random int8 operands
    for (int k = 0; k < 8; k++) begin
      mem_a[k] = {$urandom, $urandom};
      mem_b[k] = {$urandom, $urandom};
    end
    mem_a[0][63:56] = 8'h5a;
    go(8);
    run_to_done(80);
    chk("k8_done_cycle", 64'(done_cyc), 25);
    chk("k8_rd_count", 64'(n_rd), 8);
    chk("k8_addr_seq_errs", 64'(addr_bad), 0);
    chk("k8_a7_first_cyc", 64'(a7_cyc), 10);
    chk("k8_c_golden_errs", 64'(c_errs(8)), 0);

    // K=0: clear then done
    go(0);
    run_to_done(20);
    chk("k0_done_cycle", 64'(done_cyc), 2);
    chk("k0_rd_count", 64'(n_rd), 0);
    chk("k0_busy_cycles", 64'(n_busy), 2);
    chk("k0_c_zero_errs", 64'(c_errs(0)), 0);

    // K=4 with start re-pulsed during FEED
    go(4);
    step();
    step();
    start = 1'b1;
    k_len = 8'd9;
    step();
    start = 1'b0;
    run_to_done(60);
    chk("k4_repulse_done_cycle", 64'(done_cyc), 21);
    chk("k4_repulse_done_count", 64'(n_done), 1);
    chk("k4_repulse_rd_count", 64'(n_rd), 4);
    chk("k4_repulse_c_errs", 64'(c_errs(4)), 0);

    // start while unlocked is ignored
    arr_locked = 1'b0;
    go(2);
    repeat (4) step();
    chk("unlocked_busy", 64'(n_busy), 0);
    chk("unlocked_done", 64'(n_done), 0);
    chk("unlocked_c_kept", 64'(c_errs(4)), 0);
    arr_locked = 1'b1;
    step();

    // Lock lost at FEED t=3 of a K=8 run
    go(8);
    while (cyc < 5) step();
    arr_locked = 1'b0;
    step();
    chk("abort_pulse", 64'(abort), 1);
    chk("abort_arr_en", 64'(arr_en), 0);
    chk("abort_a_in", a_in_flat, 0);
    chk("abort_b_in", b_in_flat, 0);
    chk("abort_busy", 64'(busy), 0);
    repeat (25) step();
    chk("abort_no_done", 64'(n_done), 0);
    chk("abort_single_pulse", 64'(n_abort), 1);
    arr_locked = 1'b1;
    step();
    go(1);
    run_to_done(40);
    chk("post_abort_done_cycle", 64'(done_cyc), 18);
    chk("post_abort_c_errs", 64'(c_errs(1)), 0);

    // Reset at DRAIN cycle 5 of a K=4 run
    go(4);
    while (cyc < 11) step();
    chk("pre_rst_in_drain", 64'({arr_en, mem_rd_en}), 64'b10);
    rst = 1'b1;
    step();
    chk("midrun_rst_ctrl", 64'({mem_rd_en, mem_addr, arr_en, arr_clr, busy, done, abort}), 0);
    chk("midrun_rst_a_in", a_in_flat, 0);
    chk("midrun_rst_b_in", b_in_flat, 0);
    start = 1'b1;
    k_len = 8'd4;
    step();
    start = 1'b0;
    rst   = 1'b0;
    step();
    chk("start_with_rst_busy", 64'(busy), 0);
    go(4);
    run_to_done(60);
    chk("post_rst_done_cycle", 64'(done_cyc), 21);
    chk("post_rst_c_errs", 64'(c_errs(4)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
